mem_responder: RTL and testbench
================================

# mem_responder

Synthesizable memory-side responder for the tagged, split-transaction processor/memory bus used by the instruction and data caches. It accepts one `BUS_LOAD` or `BUS_STORE` per cycle and grants each accepted request a nonzero 4-bit response tag in the same cycle. It returns load data with that tag a fixed `LATENCY` cycles later. It replaces the behavioural memory model in cache-level benches and stands in for the memory subsystem in small configurations.

## Interface
- `LATENCY`, 4: cycles from load acceptance to data return; legal range 1..15 (elaboration error otherwise).
- `ADDR_BITS`, 10: word-index width; backing array is 2^ADDR_BITS × 64 bits.
- `STALL_PERIOD`, 5: refusal period, used only when `MEM_RESP_STALL_EN` is defined; legal range 2..15.
- `clock` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `proc2mem_command` input 2: bus command.
- `proc2mem_addr` input 64: byte address; bits [2:0] are ignored.
- `proc2mem_data` input 64: store data.
- `mem2proc_response` output 4: accepted tag (1..15), or 0 for not accepted.
- `mem2proc_data` output 64: load return data; valid when `mem2proc_tag` != 0.
- `mem2proc_tag` output 4: tag of the load completing this cycle; 0 means none.

## Operation
- Word index = `proc2mem_addr[ADDR_BITS+2:3]`. Upper address bits are ignored, so addresses alias modulo the array size.
- Command encodings: `BUS_NONE`=0, `BUS_LOAD`=1, `BUS_STORE`=2. Encoding 3 is treated as `BUS_NONE`.
- Accept condition: command is LOAD or STORE, and `reset` is low, and no stall is active.
- `mem2proc_response` is combinational: it equals `next_tag` when the request is accepted, otherwise 0.
- `next_tag`: 4-bit register, reset value 1. It advances on every accepted request (load or store) through 1→2→…→15→1 and never takes the value 0.
- Uniqueness: at most `LATENCY` ≤ 15 loads are ever in flight, so a live tag is never reissued.
- Accepted STORE: the array word is written at the accepting edge. A store never appears on `mem2proc_tag`.
- Accepted LOAD: the array word is read at the accepting edge. The read sees all previously accepted stores. The (tag, data) pair enters the delay line.
- Delay line: `LATENCY` stages of {valid, tag[3:0], data[63:0]}, shifting every cycle unconditionally. There is no backpressure on the return path.
- Last stage drives the outputs: `mem2proc_tag` = valid ? tag : 0, and `mem2proc_data` = valid ? data : 0.
- A return and a new acceptance may occur in the same cycle; they are independent.
- Reset, including mid-operation, clears every stage valid bit and sets `next_tag` to 1. All in-flight loads are dropped. Array contents are not reset.
- Reset values: `mem2proc_response`=0, `mem2proc_tag`=0, `mem2proc_data`=0.

## Timing
- A load accepted in cycle T (response nonzero during T) returns its data and tag throughout cycle T+`LATENCY` only, for exactly one cycle.
- Store → load to the same address in consecutive cycles: the load returns the stored value.
- Sustained throughput: one request per cycle.
- Back-to-back loads return on consecutive cycles, in acceptance order.
- Requester handling of refusals: a refused request (response 0) is not recorded. The requester re-presents it in a later cycle.

## Configuration
- `MEM_RESP_STALL_EN` defined:
  - A 4-bit stall counter (reset 0) increments every cycle and wraps from `STALL_PERIOD`-1 to 0.
  - When the counter equals `STALL_PERIOD`-1, any request is refused: response 0, no array write, no tag advance.
  - This exercises requester retry paths.
- `MEM_RESP_STALL_EN` undefined: the counter is absent and every LOAD/STORE is accepted.

## Structure
- Shared package `sys_defs` holds:
  - the bus-command typedef and the `BUS_NONE`/`BUS_LOAD`/`BUS_STORE` constants;
  - the 4-bit tag width constant and the reserved "no tag" value 0.
- Sub-module `mem_delay_line` is a parameterized `LATENCY`-stage shift register of {valid, tag, data} with synchronous clear.
- Backing array, tag counter and stall counter live in the top module.

## Test plan
- Reset then idle: hold `reset` 2 cycles → all outputs 0. First LOAD after release gets response 1.
- STORE 0xDEADBEEF_00C0FFEE to addr 0x40, then LOAD 0x40 next cycle:
  - store response 1, load response 2;
  - cycle load+4 has `mem2proc_tag`=2 and data 0xDEADBEEF_00C0FFEE, for one cycle only.
- 20 back-to-back LOADs:
  - responses 1..15 then wrap to 1..5, never 0;
  - returns on consecutive cycles in the same order, each exactly 4 cycles after its acceptance.
- Alias check with `ADDR_BITS`=10: STORE to 0x2008, then LOAD 0x0008 returns the stored value.
- Reset asserted 2 cycles after 3 LOADs accepted: no tag ever returns for them, and `next_tag` restarts at 1.
- With `MEM_RESP_STALL_EN`, `STALL_PERIOD`=5:
  - continuous LOADs get response 0 on every 5th cycle after reset;
  - the tag sequence shows no gaps;
  - a refused STORE leaves memory unchanged.

Source files
------------

// File: rtl/sys_defs.sv
// Shared bus definitions for the processor/memory split-transaction bus:
// command encodings, tag width, the reserved "no tag" value and the tag
// sequencing helper.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  localparam int TAG_BITS  = 4;
  localparam int DATA_BITS = 64;

  // Tag 0 on the bus means "nothing"; live tags run 1..15.
  localparam logic [TAG_BITS-1:0] NO_TAG = '0;

  // Advance a live tag 1->2->...->15->1, skipping the reserved 0.
  function automatic logic [TAG_BITS-1:0] tag_advance(input logic [TAG_BITS-1:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/mem_delay_line.sv
// Fixed-latency return pipe: LATENCY stages of {valid, tag, data} that shift
// every cycle. i_clear drops every in-flight entry at the next edge.
module mem_delay_line #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 64
) (
  input  logic              i_clk,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid [LATENCY];
  logic [TAG_W-1:0]  r_tag   [LATENCY];
  logic [DATA_W-1:0] r_data  [LATENCY];

  // Valid bits shift unconditionally and are the only state cleared.
  always_ff @(posedge i_clk) begin
    r_valid[0] <= i_clear ? 1'b0 : i_valid;
    for (int i = 1; i < LATENCY; i++) begin
      r_valid[i] <= i_clear ? 1'b0 : r_valid[i-1];
    end
  end

  // Payload shifts alongside; it is meaningless while its valid bit is low.
  always_ff @(posedge i_clk) begin
    r_tag[0]  <= i_tag;
    r_data[0] <= i_data;
    for (int i = 1; i < LATENCY; i++) begin
      r_tag[i]  <= r_tag[i-1];
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_tag   = r_tag[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the tagged split-transaction bus. Accepts one
// load or store per cycle, grants a nonzero tag combinationally, and returns
// load data with that tag exactly LATENCY cycles later.
// Optional build macro MEM_RESP_STALL_EN: refuses every request on one cycle
// out of STALL_PERIOD, so requester retry paths get exercised.
// Handshake: a request is taken in the cycle mem2proc_response != 0; a
// response of 0 means the request was not recorded and must be re-presented.
module mem_responder
  import sys_defs::*;
#(
  parameter int LATENCY      = 4,
  parameter int ADDR_BITS    = 10,
  parameter int STALL_PERIOD = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           proc2mem_command,
  input  logic [63:0]          proc2mem_addr,
  input  logic [63:0]          proc2mem_data,
  output logic [TAG_BITS-1:0]  mem2proc_response,
  output logic [DATA_BITS-1:0] mem2proc_data,
  output logic [TAG_BITS-1:0]  mem2proc_tag
);

  // Tags 1..15 and a 4-bit stall counter bound both parameters.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end
  if (STALL_PERIOD < 2 || STALL_PERIOD > 15) begin : g_bad_stall_period
    $error("mem_responder: STALL_PERIOD must be in 2..15");
  end

  logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
  logic [TAG_BITS-1:0]  r_next_tag;

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_stall;
  logic                 w_accept;
  logic [DATA_BITS-1:0] w_rd_data;
  logic                 w_ret_valid;
  logic [TAG_BITS-1:0]  w_ret_tag;
  logic [DATA_BITS-1:0] w_ret_data;
  logic                 w_unused_addr_bits;

  // Upper address bits alias; byte-offset bits are ignored.
  assign w_idx              = proc2mem_addr[ADDR_BITS+2:3];
  assign w_unused_addr_bits = ^{proc2mem_addr[63:ADDR_BITS+3], proc2mem_addr[2:0]};

  // Encoding 3 falls through both compares and behaves as BUS_NONE.
  assign w_is_load  = (proc2mem_command == 2'(BUS_LOAD));
  assign w_is_store = (proc2mem_command == 2'(BUS_STORE));

`ifdef MEM_RESP_STALL_EN
  logic [3:0] r_stall_cnt;

  // Free-running refusal counter: 0..STALL_PERIOD-1, refuse on the last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= 4'd0;
    end else if (r_stall_cnt == 4'(STALL_PERIOD - 1)) begin
      r_stall_cnt <= 4'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 4'd1;
    end
  end

  assign w_stall = (r_stall_cnt == 4'(STALL_PERIOD - 1));
`else
  assign w_stall = 1'b0;
`endif

  assign w_accept          = (w_is_load || w_is_store) && !reset && !w_stall;
  assign mem2proc_response = w_accept ? r_next_tag : NO_TAG;

  // Tag counter advances on every accepted request, loads and stores alike.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_next_tag <= 4'd1;
    end else if (w_accept) begin
      r_next_tag <= tag_advance(r_next_tag);
    end
  end

  // Backing array: stores land at the accepting edge; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_accept && w_is_store) begin
      r_mem[w_idx] <= proc2mem_data;
    end
  end

  // Loads capture the array word at the accepting edge, so any store
  // accepted in an earlier cycle is already visible.
  assign w_rd_data = r_mem[w_idx];

  mem_delay_line #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_BITS),
    .DATA_W  (DATA_BITS)
  ) u_delay (
    .i_clk   (clock),
    .i_clear (reset),
    .i_valid (w_accept && w_is_load),
    .i_tag   (r_next_tag),
    .i_data  (w_rd_data),
    .o_valid (w_ret_valid),
    .o_tag   (w_ret_tag),
    .o_data  (w_ret_data)
  );

  // Outputs read as zero whenever no return is live, including during reset.
  assign mem2proc_tag  = (w_ret_valid && !reset) ? w_ret_tag  : NO_TAG;
  assign mem2proc_data = (w_ret_valid && !reset) ? w_ret_data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed steps followed by random traffic, all
// checked cycle by cycle against a reference model of memory, tag sequence
// and fixed-latency return schedule.
module tb_mem_responder;

  localparam int LAT = 4;
  localparam int AB  = 10;
  localparam int SP  = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [3:0]  resp;
  logic [63:0] rdata;
  logic [3:0]  rtag;

  // clock/reset block
  always #5 clock = ~clock;

  mem_responder #(
    .LATENCY      (LAT),
    .ADDR_BITS    (AB),
    .STALL_PERIOD (SP)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .mem2proc_response (resp),
    .mem2proc_data     (rdata),
    .mem2proc_tag      (rtag)
  );

  // reference model state
  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
    bit          known;
  } ret_t;

  ret_t        exp_q[$];
  logic [63:0] mem_model [int];
  int          model_tag = 1;
  int          since_rst = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", name, cyc, obs, exp);
    end
  endtask

  // driver + scoreboard: one bus cycle per call
  task automatic step(input bit rst, input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
    ret_t        e;
    bit          acc;
    bit          stall;
    int          idx;
    logic [63:0] exp_tag;
    logic [63:0] exp_data;
    bit          chk_data;
    reset = rst;
    cmd   = c;
    addr  = a;
    wdata = d;
    @(negedge clock);
    stall = 1'b0;
`ifdef MEM_RESP_STALL_EN
    stall = ((since_rst % SP) == SP - 1);
`endif
    acc = !rst && (c == 2'd1 || c == 2'd2) && !stall;
    check("response", 64'(resp), acc ? 64'(model_tag) : 64'd0);
    exp_tag  = 64'd0;
    exp_data = 64'd0;
    chk_data = 1'b1;
    if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e        = exp_q.pop_front();
      exp_tag  = 64'(e.tag);
      exp_data = e.data;
      chk_data = e.known;
    end
    check("ret_tag", 64'(rtag), exp_tag);
    if (chk_data) check("ret_data", rdata, exp_data);
    idx = int'((a >> 3) % (64'd1 << AB));
    if (rst) begin
      exp_q.delete();
      model_tag = 1;
      since_rst = 0;
    end else begin
      since_rst++;
      if (acc) begin
        if (c == 2'd2) begin
          mem_model[idx] = d;
        end else begin
          e.due   = cyc + LAT;
          e.tag   = 4'(model_tag);
          e.known = mem_model.exists(idx);
          e.data  = e.known ? mem_model[idx] : 64'd0;
          exp_q.push_back(e);
        end
        model_tag = (model_tag % 15) + 1;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 64'd0, 64'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'd0, 64'd0, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    cmd   = 2'd0;
    addr  = 64'd0;
    wdata = 64'd0;

    // reset then idle; first load gets tag 1
    do_reset(2);
    idle(2);
    step(1'b0, 2'd1, 64'h40, 64'd0);
    idle(LAT + 2);

    // store then load same address on the next cycle
    do_reset(1);
    step(1'b0, 2'd2, 64'h40, 64'hDEADBEEF_00C0FFEE);
    step(1'b0, 2'd1, 64'h40, 64'd0);
    idle(LAT + 2);

    // aliasing: 0x2008 and 0x0008 share a word; low bits ignored
    step(1'b0, 2'd2, 64'h2008, 64'h1234_5678_9ABC_DEF0);
    step(1'b0, 2'd1, 64'h000F, 64'd0);
    step(1'b0, 2'd3, 64'h0008, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 2'd1, 64'hFFFF_0000_0000_0008, 64'd0);
    idle(LAT + 2);

    // fill words 0..31 with random data
    for (int w = 0; w < 32; w++) step(1'b0, 2'd2, 64'(w) << 3, {$urandom, $urandom});
    idle(2);

    // 20 back-to-back loads from a fresh tag sequence
    do_reset(1);
    for (int w = 0; w < 20; w++) step(1'b0, 2'd1, 64'(w) << 3, 64'd0);
    idle(LAT + 2);

    // reset mid-flight drops pending loads and restarts tags
    for (int w = 0; w < 3; w++) step(1'b0, 2'd1, 64'(w + 5) << 3, 64'd0);
    idle(1);
    do_reset(2);
    idle(LAT + 2);
    step(1'b0, 2'd1, 64'h18, 64'd0);
    idle(LAT + 1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      int          w;
      logic [63:0] a;
      w = int'($urandom_range(0, 31));
      a = ({$urandom, $urandom} & ~64'h1FF8) | (64'(w) << 3);
      step($urandom_range(0, 99) < 2, 2'($urandom_range(0, 3)), a, {$urandom, $urandom});
    end
    idle(LAT + 2);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
